uart_bus_responder: RTL and testbench

//  Memory-mapped 8N1 UART responder on the processor peripheral bus (read/write request,

---
 rtl/uart_bus_responder_if.sv | 12 +
 rtl/uart_bus_responder.sv | 200 ++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_responder_if.sv
// Peripheral bus bundle for the UART responder: request/address/payload in, data/completion out.
interface uart_bus_responder_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response;

  modport master (output read, write, address, write_data, input read_data, response);
  modport slave  (input read, write, address, write_data, output read_data, response);
endinterface

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART responder with TX/RX byte FIFOs, STATUS flags and a fixed baud divisor.
module uart_bus_responder #(
  parameter int unsigned CLOCK_FREQ           = 25000000,
  parameter int unsigned BAUD_RATE            = 9600,
  parameter logic [31:0] DEVICE_START_ADDRESS = 32'h00002000,
  parameter logic [31:0] DEVICE_FINAL_ADDRESS = 32'h0000200C,
  parameter int unsigned BUFFER_SIZE          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_bus_responder_if.slave        bus,
  input  logic                       rx,
  output logic                       tx
);

  localparam int unsigned DIV      = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW       = $clog2(BUFFER_SIZE);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bus decode
  logic       sel, req, do_write, do_read, stat_clr;
  logic [1:0] reg_idx;
  logic [31:0] rd_mux;

  assign sel      = (bus.address >= DEVICE_START_ADDRESS) && (bus.address <= DEVICE_FINAL_ADDRESS);
  assign req      = (bus.read | bus.write) & sel & ~bus.response;
  assign reg_idx  = 2'((bus.address - DEVICE_START_ADDRESS) >> 2);
  assign do_write = req & bus.write;
  assign do_read  = req & bus.read & ~bus.write;
  assign stat_clr = do_read && (reg_idx == 2'd2);

  // FIFOs
  logic [7:0]  tx_mem [BUFFER_SIZE];
  logic [7:0]  rx_mem [BUFFER_SIZE];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  // TX engine
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_busy;

  assign tx_busy = (tx_state != ST_IDLE);
  assign tx_push = do_write && (reg_idx == 2'd0) && !tx_full;
  assign tx_pop  = (tx_state == ST_IDLE) && !tx_empty;

  // RX engine
  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_smp, rx_good, ferr_set, ovr_set;
  logic          overrun, frame_err;

  assign rx_stop_smp = (rx_state == ST_STOP) && (rx_cnt == DIV_LAST);
  assign rx_good     = rx_stop_smp & rx_s2;
  assign ferr_set    = rx_stop_smp & ~rx_s2;
  assign ovr_set     = rx_good & rx_full;
  assign rx_push     = rx_good & ~rx_full;
  assign rx_pop      = do_read && (reg_idx == 2'd1) && !rx_empty;

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      2'd1:    if (!rx_empty) rd_mux = {23'b0, 1'b1, rx_mem[rx_rp[AW-1:0]]};
      2'd2:    rd_mux = {25'b0, tx_busy, frame_err, overrun, rx_full, rx_empty, tx_empty, tx_full};
      2'd3:    rd_mux = 32'(DIV);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.write_data[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.response  <= 1'b0;
      bus.read_data <= '0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bus.response  <= req;
      bus.read_data <= do_read ? rd_mux : '0;
      // A flag raised in the same cycle as a STATUS read survives the clear.
      if (ovr_set)       overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (ferr_set)      frame_err <= 1'b1;
      else if (stat_clr) frame_err <= 1'b0;
    end
  end

  // tx is registered and loaded with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: if (!tx_empty) begin
          tx_shift <= tx_mem[tx_rp[AW-1:0]];
          tx_cnt   <= '0;
          tx_state <= ST_START;
          tx       <= 1'b0;
        end
        ST_START: if (tx_cnt == DIV_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_state <= ST_DATA;
          tx       <= tx_shift[0];
        end else tx_cnt <= tx_cnt + 1'b1;
        ST_DATA: if (tx_cnt == DIV_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= ST_STOP;
            tx       <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx       <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: if (tx_cnt == DIV_LAST) begin
          tx_cnt   <= '0;
          tx_state <= ST_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        ST_IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= '0;
          rx_state <= ST_START;
        end
        // Mid-start-bit recheck rejects short low glitches.
        ST_START: if (rx_cnt == DIV_HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        ST_DATA: if (rx_cnt == DIV_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= ST_STOP;
          else                rx_bit   <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: if (rx_cnt == DIV_LAST) begin
          rx_cnt   <= '0;
          rx_state <= ST_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder with DIV=4 and 4-entry FIFOs.
module tb_uart_bus_responder;

  localparam logic [31:0] A_TX   = 32'h2000;
  localparam logic [31:0] A_RX   = 32'h2004;
  localparam logic [31:0] A_STAT = 32'h2008;
  localparam logic [31:0] A_DIV  = 32'h200C;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line;
  logic tx;

  uart_bus_responder_if bus();

  assign rx_line = loop_en ? tx : rx_drv;

  uart_bus_responder #(
    .CLOCK_FREQ(40),
    .BAUD_RATE(10),
    .DEVICE_START_ADDRESS(32'h00002000),
    .DEVICE_FINAL_ADDRESS(32'h0000200C),
    .BUFFER_SIZE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .rx(rx_line),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int vid = 0;
  logic [7:0] got [5];
  bit         gok [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic resp, output logic [31:0] rdata);
    @(negedge clk);
    bus.read = rd; bus.write = wr; bus.address = addr; bus.write_data = wdata;
    resp = 1'b0;
    rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdata = bus.read_data;
      if (bus.response) begin
        resp = 1'b1;
        break;
      end
    end
    bus.read = 1'b0; bus.write = 1'b0;
    if (resp) begin
      @(negedge clk);
      check("response_one_cycle", {31'b0, bus.response}, 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic er, input logic [31:0] ed);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_resp = er; v.exp_rdata = ed;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic        r;
    logic [31:0] d;
    bus_op(v.rd, v.wr, v.addr, v.wdata, r, d);
    check($sformatf("vec%0d_resp", vid), {31'b0, r}, {31'b0, v.exp_resp});
    check($sformatf("vec%0d_rdata", vid), d, v.exp_rdata);
    vid++;
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Decode one frame on tx by mid-bit sampling; ok is false on timeout, bad start or bad stop.
  task automatic decode_tx(output logic [7:0] b, output bit ok);
    b = '0;
    wait_tx_low(200, ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (4) @(negedge clk);
    end
    rx_drv = stop;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tab [$];
    logic        r;
    logic [31:0] d;
    logic [9:0]  frame;
    logic [7:0]  fb;
    bit          ok;

    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.write_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_response", {31'b0, bus.response}, 32'd0);
    check("reset_read_data", bus.read_data, 32'd0);
    rst = 1'b0;

    // Register map and address decode from the reset state
    tab.push_back(mk(1, 0, A_STAT, 0,       1, 32'h06));
    tab.push_back(mk(1, 0, A_DIV,  0,       1, 32'd4));
    tab.push_back(mk(1, 0, A_RX,   0,       1, 32'h0));
    tab.push_back(mk(1, 0, A_TX,   0,       1, 32'h0));
    tab.push_back(mk(0, 1, A_DIV,  32'hFF,  1, 32'h0));
    tab.push_back(mk(1, 0, A_DIV,  0,       1, 32'd4));
    tab.push_back(mk(1, 0, 32'h3000, 0,     0, 32'h0));
    tab.push_back(mk(1, 0, 32'h1FFC, 0,     0, 32'h0));
    tab.push_back(mk(1, 0, 32'h2010, 0,     0, 32'h0));
    tab.push_back(mk(0, 1, 32'h3000, 32'h55, 0, 32'h0));
    tab.push_back(mk(1, 1, A_STAT, 0,       1, 32'h0));
    tab.push_back(mk(1, 0, A_STAT, 0,       1, 32'h06));
    foreach (tab[i]) apply(tab[i]);

    // Single byte on the line, looped back into the receiver
    loop_en = 1'b1;
    bus_op(0, 1, A_TX, 32'h1A5, r, d);
    check("tx_write_resp", {31'b0, r}, 32'd1);
    fb = 8'hA5;
    frame = {1'b1, fb, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx_line_clk%0d", i), {31'b0, tx}, {31'b0, frame[i/4]});
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    tab.delete();
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h02));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h1A5));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h0));
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h06));
    foreach (tab[i]) apply(tab[i]);

    // Two bytes back to back through the loop
    bus_op(0, 1, A_TX, 32'h3C, r, d);
    bus_op(0, 1, A_TX, 32'hC3, r, d);
    repeat (110) @(negedge clk);
    tab.delete();
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h13C));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h1C3));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h0));
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h06));
    foreach (tab[i]) apply(tab[i]);
    loop_en = 1'b0;

    // Six writes against a 4-deep TX FIFO while the shifter is busy
    fork
      begin
        logic        wr_r;
        logic [31:0] wr_d;
        for (int i = 0; i < 6; i++) bus_op(0, 1, A_TX, 32'h11 + 32'(i), wr_r, wr_d);
        bus_op(1, 0, A_STAT, 0, wr_r, wr_d);
        check("status_tx_full_busy", wr_d, 32'h45);
      end
      begin
        for (int j = 0; j < 5; j++) decode_tx(got[j], gok[j]);
      end
    join
    for (int j = 0; j < 5; j++) begin
      check($sformatf("burst_frame%0d_ok", j), {31'b0, gok[j]}, 32'd1);
      check($sformatf("burst_frame%0d_byte", j), {24'b0, got[j]}, 32'h11 + 32'(j));
    end
    wait_tx_low(80, ok);
    check("burst_sixth_dropped", {31'b0, ok}, 32'd0);
    apply(mk(1, 0, A_STAT, 0, 1, 32'h06));

    // Five received frames against a 4-deep RX FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    tab.delete();
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h1A));
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h0A));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h101));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h102));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h103));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h104));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h0));
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h06));
    foreach (tab[i]) apply(tab[i]);

    // Framing error, then a short glitch, then a good frame
    send_rx(8'h55, 1'b0);
    tab.delete();
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h26));
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h06));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h0));
    foreach (tab[i]) apply(tab[i]);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    tab.delete();
    tab.push_back(mk(1, 0, A_STAT, 0, 1, 32'h06));
    tab.push_back(mk(1, 0, A_RX,   0, 1, 32'h0));
    foreach (tab[i]) apply(tab[i]);
    send_rx(8'h5A, 1'b1);
    apply(mk(1, 0, A_RX, 0, 1, 32'h15A));

    // Reset in the middle of a byte
    bus_op(0, 1, A_TX, 32'h00, r, d);
    repeat (12) @(negedge clk);
    check("tx_mid_byte_low", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("tx_after_reset", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_tx_low(60, ok);
    check("tx_idle_after_reset", {31'b0, ok}, 32'd0);
    apply(mk(1, 0, A_STAT, 0, 1, 32'h06));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
